multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Moore-style control FSM that sequences a shared-resource (multicycle) MIPS datapath: one ALU, one unified instruction/data memory, IR and ALUOut registers.
- Replaces the single-cycle combinational control/PC-update path.
- Drives every datapath enable and mux select per state.
- Handles variable-latency memory through a ready handshake with timeout.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles for mem_ready before abort (1..2^TIMEOUT_W-1).
- TIMEOUT_W, 4: width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  instruction[31:26] from IR.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load IR.
- RegDst  out  1  write-register select: 0=rt, 1=rd.
- MemtoReg  out  1  write-data select: 0=ALUOut, 1=MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=rs.
- ALUSrcB  out  2  ALU B select: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2.
- ALUOp  out  3  to ALUControl: 000 add, 001 sub, 010 funct, 011 or, 100 and, 101 lui.
- PCSource  out  2  PC mux: 00=ALU result, 01=ALUOut, 10=jump target.
- PCWrite  out  1  PC load enable; branch condition already resolved inside.
- State  out  4  current state (debug).
- mem_err  out  1  one-cycle pulse on memory timeout.
- illegal_op  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11.
- Reset (reset=0, async): State=FETCH, wait counter=0. All outputs take FETCH-idle values: MemRead=1, ALUSrcB=01, every write enable 0, mem_err=0, illegal_op=0.
- Unlisted outputs are 0 in every state.
- FETCH:
  - IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready (combinational).
  - On mem_ready: go to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut).
  - Opcode dispatch:
    - 0x00 -> EXEC_R
    - 0x23/0x2B -> MEM_ADDR
    - 0x08/0x0D/0x0C/0x0F -> EXEC_I
    - 0x04/0x05 -> BRANCH
    - 0x02 -> JUMP
    - other -> FETCH, with illegal_op=1 for this cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: IorD=1, MemRead=1. Stays until mem_ready, then -> MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. Stays until mem_ready, then -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010 -> R_WB.
- R_WB: RegDst=1, RegWrite=1, MemtoReg=0 -> FETCH.
- EXEC_I:
  - ALUSrcA=1, ALUSrcB=10.
  - ALUOp: 000 for 0x08, 011 for 0x0D, 100 for 0x0C, 101 for 0x0F.
  - -> I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01.
  - PCWrite = Zero for 0x04, ~Zero for 0x05 (combinational in this cycle).
  - -> FETCH.
- JUMP: PCSource=10, PCWrite=1 -> FETCH.
- Opcode is sampled combinationally in DECODE, MEM_ADDR, EXEC_I and BRANCH; IR holds it stable from FETCH completion onward.
- Latency with zero-wait memory (mem_ready=1 on first request cycle), in cycles:
  - lw 5; sw 4; R-type 4; I-type ALU 4; branch 3; j 3.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH/MEM_READ/MEM_WRITE.
  - Increments each cycle in those states while mem_ready=0.
  - If it reaches MEM_TIMEOUT with mem_ready still 0: mem_err=1 for one cycle, the access is aborted with no IRWrite/PCWrite/RegWrite, and the FSM goes to FETCH.
  - FETCH timeout refetches the same PC.
- mem_ready in the same cycle as timeout: treated as success, no mem_err.
- mem_ready outside the three memory states is ignored.
- Reset asserted mid-instruction: immediate return to FETCH. No partial register/PC write occurs after the reset edge.
- Illegal or unreachable state encoding (12..15) -> FETCH on the next clock, outputs idle.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> State=0, MemRead=1, PCWrite=0 until mem_ready=1, then IRWrite=PCWrite=1 for exactly that one cycle.
- R-type: Opcode=0x00, mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7. ALUOp=010 in state 6.
- lw with 3 wait cycles in MEM_READ: Opcode=0x23 -> states 0,1,2,3,3,3,3,4,0. IorD=1 throughout state 3. RegWrite with MemtoReg=1 in state 4.
- Branches in BRANCH state:
  - beq 0x04: Zero=1 -> PCWrite=1, PCSource=01; Zero=0 -> PCWrite=0.
  - bne 0x05: Zero=0 -> PCWrite=1; Zero=1 -> PCWrite=0.
- Timeout: MEM_TIMEOUT=15, Opcode=0x2B, mem_ready held 0 -> mem_err pulses exactly once, after 15 cycles in state 5. Next state 0, MemWrite drops.
- Illegal opcode 0x3F -> illegal_op=1 during DECODE, next state FETCH, no RegWrite/PCWrite. Asserting reset during state 3 forces State=0 asynchronously.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore-style control FSM for a multicycle MIPS datapath with a shared ALU,
// a unified instruction/data memory and IR/ALUOut registers. Memory accesses
// use a ready handshake guarded by a wait counter that aborts a stalled access.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMEOUT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic [3:0] State,
    output logic       mem_err,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        EXEC_I    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // The counter holds (cycles already waited); the abort fires on the
    // MEM_TIMEOUT-th stalled cycle of an access.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE       = TIMEOUT_W'(1);

    state_t               state_r;
    state_t               next_state_s;
    logic [TIMEOUT_W-1:0] wait_cnt_r;
    logic [TIMEOUT_W-1:0] wait_cnt_next_s;
    logic                 mem_state_s;
    logic                 timeout_s;

    assign State = state_r;

    // Memory-wait bookkeeping: detect a stalled access and compute the next count.
    always_comb begin
        mem_state_s     = 1'b0;
        timeout_s       = 1'b0;
        wait_cnt_next_s = {TIMEOUT_W{1'b0}};
        if ((state_r == FETCH) || (state_r == MEM_READ) || (state_r == MEM_WRITE)) begin
            mem_state_s = 1'b1;
        end else begin
            mem_state_s = 1'b0;
        end
        if (mem_state_s && !mem_ready && (wait_cnt_r == TIMEOUT_LIMIT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        // Leaving a memory state requires ready or timeout, so clearing on
        // those also clears the count on every entry (including a refetch).
        if (mem_state_s && !mem_ready && !timeout_s) begin
            wait_cnt_next_s = wait_cnt_r + CNT_ONE;
        end else begin
            wait_cnt_next_s = {TIMEOUT_W{1'b0}};
        end
    end

    // State and wait-counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= FETCH;
            wait_cnt_r <= {TIMEOUT_W{1'b0}};
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Next-state decode and per-state datapath controls.
    always_comb begin
        next_state_s = FETCH;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 3'b000;
        PCSource     = 2'b00;
        PCWrite      = 1'b0;
        mem_err      = 1'b0;
        illegal_op   = 1'b0;
        case (state_r)
            FETCH: begin
                // PC+4 computed while the instruction is read; writes are
                // gated by reset so nothing commits while it is asserted.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite      = reset;
                    PCWrite      = reset;
                    next_state_s = DECODE;
                end else if (timeout_s) begin
                    mem_err      = reset;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                // Speculative branch target (PC + imm<<2) into ALUOut.
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE:                         next_state_s = EXEC_R;
                    OP_LW, OP_SW:                     next_state_s = MEM_ADDR;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: next_state_s = EXEC_I;
                    OP_BEQ, OP_BNE:                   next_state_s = BRANCH;
                    OP_J:                             next_state_s = JUMP;
                    default: begin
                        illegal_op   = 1'b1;
                        next_state_s = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Opcode == OP_LW) begin
                    next_state_s = MEM_READ;
                end else if (Opcode == OP_SW) begin
                    next_state_s = MEM_WRITE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    next_state_s = MEM_WB;
                end else if (timeout_s) begin
                    mem_err      = reset;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEM_READ;
                end
            end
            MEM_WB: begin
                MemtoReg     = 1'b1;
                RegWrite     = 1'b1;
                next_state_s = FETCH;
            end
            MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    next_state_s = FETCH;
                end else if (timeout_s) begin
                    mem_err      = reset;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEM_WRITE;
                end
            end
            EXEC_R: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b00;
                ALUOp        = 3'b010;
                next_state_s = R_WB;
            end
            R_WB: begin
                RegDst       = 1'b1;
                RegWrite     = 1'b1;
                next_state_s = FETCH;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Opcode)
                    OP_ADDI: ALUOp = 3'b000;
                    OP_ORI:  ALUOp = 3'b011;
                    OP_ANDI: ALUOp = 3'b100;
                    OP_LUI:  ALUOp = 3'b101;
                    default: ALUOp = 3'b000;
                endcase
                next_state_s = I_WB;
            end
            I_WB: begin
                RegWrite     = 1'b1;
                next_state_s = FETCH;
            end
            BRANCH: begin
                // Compare rs-rt; the PC takes the target held in ALUOut.
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b00;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                if (Opcode == OP_BEQ) begin
                    PCWrite = Zero;
                end else if (Opcode == OP_BNE) begin
                    PCWrite = ~Zero;
                end else begin
                    PCWrite = 1'b0;
                end
                next_state_s = FETCH;
            end
            JUMP: begin
                PCSource     = 2'b10;
                PCWrite      = 1'b1;
                next_state_s = FETCH;
            end
            default: begin
                // Unreachable encodings: idle outputs, recover to FETCH.
                next_state_s = FETCH;
            end
        endcase
    end

endmodule
